// File: rtl/aes_tg_pkg.sv
// Shared types and LFSR helper for the AES traffic generator.
package aes_tg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StKeyInit,
    StKeyWait,
    StRun,
    StDone
  } tg_state_e;

  // Galois form of x^128 + x^29 + x^27 + x^2 + 1.
  localparam logic [127:0] LFSR_TAPS = 128'h2800_0005;

  function automatic logic [127:0] lfsr_next(input logic [127:0] v);
    lfsr_next = {v[126:0], 1'b0} ^ (v[127] ? LFSR_TAPS : 128'h0);
  endfunction

endpackage

// File: rtl/aes_tg_fifo.sv
// Synchronous FIFO; the head word is read straight from the storage flops.
module aes_tg_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + (PtrW + 1)'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/aes_traffic_gen.sv
// AES traffic generator: key sequencing, LFSR plaintext issue and plaintext/result buffering.
module aes_traffic_gen
  import aes_tg_pkg::*;
#(
  parameter int unsigned  DEPTH   = 16,
  parameter int unsigned  CNT_W   = 32,
  parameter logic [127:0] SEED    = 128'h1,
  parameter logic [127:0] KEY_RST = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_i,
  input  logic             work_i,
  input  logic [CNT_W-1:0] block_count_i,
  input  logic             start_i,
  input  logic [127:0]     key_i,
  input  logic             write_key_i,
  input  logic [127:0]     seed_i,
  input  logic             write_seed_i,
  input  logic             data_require_i,
  output logic [127:0]     data_o,
  output logic             data_empty_o,
  input  logic             result_require_i,
  output logic [127:0]     result_o,
  output logic             result_empty_o,
  output logic             core_init_o,
  output logic             core_next_o,
  output logic             core_encdec_o,
  output logic [127:0]     core_key_o,
  output logic [127:0]     core_block_o,
  input  logic             core_ready_i,
  input  logic [127:0]     core_result_i,
  input  logic             core_result_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] issued_cnt_o,
  output logic [CNT_W-1:0] result_cnt_o
);

  tg_state_e        state_q, state_d;
  logic             pending_q, pending_d;
  logic             run_active_q, run_active_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] rescnt_q, rescnt_d;
  logic [127:0]     lfsr_q, lfsr_d;
  logic [127:0]     key_q, key_d;
  logic [127:0]     block_q, block_d;
  logic             encdec_q, encdec_d;
  logic             init_q, init_d;
  logic             next_q, next_d;
  logic             issue, capture, limit;
  logic             data_full, res_full;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    run_active_d = run_active_q;
    issued_d     = issued_q;
    rescnt_d     = rescnt_q;
    lfsr_d       = lfsr_q;
    key_d        = key_q;
    block_d      = block_q;
    encdec_d     = encdec_q;
    init_d       = 1'b0;
    next_d       = 1'b0;
    issue        = 1'b0;
    limit        = (block_count_i != '0) && (issued_q == block_count_i);
    // The core still shows the previous result while next_q is being seen, so skip that cycle.
    capture      = pending_q & ~next_q & core_ready_i & core_result_valid_i;

    if (capture) begin
      pending_d = 1'b0;
      if (rescnt_q != '1) begin
        rescnt_d = rescnt_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d      = StRun;
          run_active_d = 1'b1;
          issued_d     = '0;
          rescnt_d     = '0;
        end
      end
      StKeyInit: begin
        if (core_ready_i && !pending_q) begin
          init_d  = 1'b1;
          state_d = StKeyWait;
        end
      end
      StKeyWait: begin
        if (core_ready_i && !init_q) begin
          state_d = run_active_q ? StRun : StIdle;
        end
      end
      StRun: begin
        issue = work_i & core_ready_i & ~pending_q & ~data_full & ~res_full & ~limit;
        if (limit && !pending_q) begin
          state_d      = StDone;
          run_active_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      next_d    = 1'b1;
      pending_d = 1'b1;
      block_d   = lfsr_q;
      encdec_d  = enc_i;
      lfsr_d    = lfsr_next(lfsr_q);
      if (issued_q != '1) begin
        issued_d = issued_q + CNT_W'(1);
      end
    end

    if (write_seed_i && (seed_i != '0)) begin
      lfsr_d = seed_i;
    end

    // KEY_INIT itself holds off until any pending block has been captured.
    if (write_key_i) begin
      key_d   = key_i;
      state_d = StKeyInit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StKeyInit;
      pending_q    <= 1'b0;
      run_active_q <= 1'b0;
      issued_q     <= '0;
      rescnt_q     <= '0;
      lfsr_q       <= SEED;
      key_q        <= KEY_RST;
      block_q      <= SEED;
      encdec_q     <= 1'b0;
      init_q       <= 1'b0;
      next_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      run_active_q <= run_active_d;
      issued_q     <= issued_d;
      rescnt_q     <= rescnt_d;
      lfsr_q       <= lfsr_d;
      key_q        <= key_d;
      block_q      <= block_d;
      encdec_q     <= encdec_d;
      init_q       <= init_d;
      next_q       <= next_d;
    end
  end

  aes_tg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (128)
  ) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (issue),
    .wdata_i (lfsr_q),
    .pop_i   (data_require_i),
    .rdata_o (data_o),
    .empty_o (data_empty_o),
    .full_o  (data_full)
  );

  aes_tg_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (128)
  ) u_result_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (capture),
    .wdata_i (core_result_i),
    .pop_i   (result_require_i),
    .rdata_o (result_o),
    .empty_o (result_empty_o),
    .full_o  (res_full)
  );

  assign core_init_o   = init_q;
  assign core_next_o   = next_q;
  assign core_encdec_o = encdec_q;
  assign core_key_o    = key_q;
  assign core_block_o  = block_q;
  assign busy_o        = !((state_q == StIdle) || (state_q == StDone));
  assign done_o        = (state_q == StDone);
  assign issued_cnt_o  = issued_q;
  assign result_cnt_o  = rescnt_q;

endmodule

// File: tb/tb_aes_traffic_gen.sv
// Bench for aes_traffic_gen: behavioural AES core stand-in, LFSR model and FIFO scoreboards.
module tb_aes_traffic_gen;

  localparam int unsigned  Depth  = 4;
  localparam int           Lat    = 10;
  localparam logic [127:0] KeyRst = 128'hab7240f9_c5e0bb5e_ee8e34b6_bb84cfb0;
  localparam logic [127:0] Key2   = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enc_i, work_i, start_i, write_key_i, write_seed_i;
  logic [31:0]  block_count_i;
  logic [127:0] key_i, seed_i;
  logic         data_require_i, result_require_i;
  logic [127:0] data_o, result_o, core_key_o, core_block_o;
  logic         data_empty_o, result_empty_o, core_init_o, core_next_o, core_encdec_o;
  logic         busy_o, done_o;
  logic [31:0]  issued_cnt_o, result_cnt_o;

  logic         c_ready, c_valid, c_is_blk;
  logic [127:0] c_res;
  int           c_cnt;

  always #5 clk = ~clk;

  aes_traffic_gen #(
    .DEPTH (Depth),
    .CNT_W (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enc_i               (enc_i),
    .work_i              (work_i),
    .block_count_i       (block_count_i),
    .start_i             (start_i),
    .key_i               (key_i),
    .write_key_i         (write_key_i),
    .seed_i              (seed_i),
    .write_seed_i        (write_seed_i),
    .data_require_i      (data_require_i),
    .data_o              (data_o),
    .data_empty_o        (data_empty_o),
    .result_require_i    (result_require_i),
    .result_o            (result_o),
    .result_empty_o      (result_empty_o),
    .core_init_o         (core_init_o),
    .core_next_o         (core_next_o),
    .core_encdec_o       (core_encdec_o),
    .core_key_o          (core_key_o),
    .core_block_o        (core_block_o),
    .core_ready_i        (c_ready),
    .core_result_i       (c_res),
    .core_result_valid_i (c_valid),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .issued_cnt_o        (issued_cnt_o),
    .result_cnt_o        (result_cnt_o)
  );

  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic [127:0] k,
                                           input logic e);
    core_fn = {blk[63:0], blk[127:64]} ^ k ^ {128{e}};
  endfunction

  function automatic logic [127:0] lfsr_step(input logic [127:0] v);
    logic [127:0] taps;
    taps = '0;
    taps[29] = 1'b1;
    taps[27] = 1'b1;
    taps[2] = 1'b1;
    taps[0] = 1'b1;
    lfsr_step = {v[126:0], 1'b0} ^ (v[127] ? taps : 128'h0);
  endfunction

  // Stand-in AES core: drops ready on init/next, returns a keyed result Lat cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_ready  <= 1'b1;
      c_valid  <= 1'b0;
      c_is_blk <= 1'b0;
      c_cnt    <= 0;
      c_res    <= '0;
    end else if (core_init_o || core_next_o) begin
      c_ready  <= 1'b0;
      c_valid  <= 1'b0;
      c_cnt    <= Lat;
      c_is_blk <= core_next_o;
      if (core_next_o) c_res <= core_fn(core_block_o, core_key_o, core_encdec_o);
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        c_ready <= 1'b1;
        c_valid <= c_is_blk;
      end
    end
  end

  typedef struct {
    bit           seed_wr;
    logic [127:0] seed;
    logic [31:0]  bc;
    bit           enc;
    bit           work_tgl;
    bit           rnd_pop;
    bit           chk_head;
    logic [127:0] head;
  } run_t;

  run_t         runs[5];
  logic [127:0] exp_pt[$];
  logic [127:0] exp_res[$];
  logic [127:0] m_lfsr = 128'h1;
  logic [127:0] m_key  = KeyRst;
  int           n_chk = 0, n_err = 0;
  int           n_next = 0, n_init = 0, cyc = 0, pop_mode = 0;
  bit           work_tgl = 1'b0;

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: observe issue pulses, then decide this cycle's pops (0 none, 1 all, 2 random).
  task automatic step();
    @(negedge clk);
    cyc++;
    if (work_tgl) work_i = ((cyc / 3) % 2) == 0;
    if (core_init_o) n_init++;
    if (core_next_o) begin
      chk_w("core_block", core_block_o, m_lfsr);
      chk_i("core_encdec", int'(core_encdec_o), int'(enc_i));
      exp_pt.push_back(m_lfsr);
      exp_res.push_back(core_fn(m_lfsr, m_key, enc_i));
      m_lfsr = lfsr_step(m_lfsr);
      n_next++;
    end
    data_require_i   = 1'b0;
    result_require_i = 1'b0;
    if (pop_mode != 0 && !data_empty_o && (pop_mode == 1 || $urandom_range(0, 1) == 1)) begin
      if (exp_pt.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL data_extra: got %h expected no entry", data_o);
      end else chk_w("data", data_o, exp_pt.pop_front());
      data_require_i = 1'b1;
    end
    if (pop_mode != 0 && !result_empty_o && (pop_mode == 1 || $urandom_range(0, 1) == 1)) begin
      if (exp_res.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL result_extra: got %h expected no entry", result_o);
      end else chk_w("result", result_o, exp_res.pop_front());
      result_require_i = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    pop_mode = 1;
    for (int i = 0; i < 30; i++) step();
    pop_mode = 0;
    step();
    chk_i({tag, "_pt_left"}, exp_pt.size(), 0);
    chk_i({tag, "_res_left"}, exp_res.size(), 0);
    chk_i({tag, "_data_empty"}, int'(data_empty_o), 1);
    chk_i({tag, "_result_empty"}, int'(result_empty_o), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    runs[0] = '{1'b0, 128'h0, 32'd4, 1'b1, 1'b0, 1'b0, 1'b1, 128'h1};
    runs[1] = '{1'b1, 128'hDEAD, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1, 128'hDEAD};
    runs[2] = '{1'b1, {1'b1, 126'h0, 1'b1}, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, {1'b1, 126'h0, 1'b1}};
    runs[3] = '{1'b1, 128'h0, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1, 128'h5000_000E};
    runs[4] = '{1'b0, 128'h0, 32'd100, 1'b0, 1'b1, 1'b1, 1'b0, 128'h0};

    rst_n = 1'b0;
    enc_i = 1'b1; work_i = 1'b1; start_i = 1'b0; write_key_i = 1'b0; write_seed_i = 1'b0;
    block_count_i = '0; key_i = '0; seed_i = '0;
    data_require_i = 1'b0; result_require_i = 1'b0;

    // Reset state, then power-up key expansion ending in IDLE.
    #23;
    chk_i("rst_busy", int'(busy_o), 1);
    chk_i("rst_done", int'(done_o), 0);
    chk_i("rst_data_empty", int'(data_empty_o), 1);
    chk_i("rst_result_empty", int'(result_empty_o), 1);
    chk_i("rst_core_init", int'(core_init_o), 0);
    chk_i("rst_core_next", int'(core_next_o), 0);
    chk_i("rst_issued", int'(issued_cnt_o), 0);
    chk_w("rst_key", core_key_o, KeyRst);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60 && busy_o; i++) step();
    chk_i("init_busy", int'(busy_o), 0);
    chk_i("init_pulses", n_init, 1);
    chk_i("init_done", int'(done_o), 0);
    chk_i("init_result_cnt", int'(result_cnt_o), 0);
    chk_i("init_data_empty", int'(data_empty_o), 1);

    // Bounded runs: seed loads, boundary counts and a long randomised run.
    for (int r = 0; r < 5; r++) begin
      if (runs[r].seed_wr) begin
        seed_i = runs[r].seed;
        write_seed_i = 1'b1;
        step();
        write_seed_i = 1'b0;
        if (runs[r].seed != '0) m_lfsr = runs[r].seed;
      end
      block_count_i = runs[r].bc;
      enc_i = runs[r].enc;
      work_tgl = runs[r].work_tgl;
      pop_mode = runs[r].rnd_pop ? 2 : 0;
      n_next = 0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 4000 && !done_o; i++) step();
      work_tgl = 1'b0;
      work_i = 1'b1;
      chk_i($sformatf("run%0d_done", r), int'(done_o), 1);
      chk_i($sformatf("run%0d_busy", r), int'(busy_o), 0);
      chk_i($sformatf("run%0d_issued", r), int'(issued_cnt_o), int'(runs[r].bc));
      chk_i($sformatf("run%0d_results", r), int'(result_cnt_o), int'(runs[r].bc));
      chk_i($sformatf("run%0d_next_pulses", r), n_next, int'(runs[r].bc));
      if (runs[r].chk_head) chk_w($sformatf("run%0d_head", r), data_o, runs[r].head);
      drain($sformatf("run%0d", r));
    end

    // Key change while a block is in flight.
    block_count_i = 32'd6;
    enc_i = 1'b1;
    pop_mode = 1;
    n_next = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 200 && n_next < 2; i++) step();
    chk_i("wk_second_issue", n_next, 2);
    repeat (3) step();
    chk_i("wk_pre_results", int'(result_cnt_o), 1);
    key_i = Key2;
    write_key_i = 1'b1;
    m_key = Key2;
    step();
    write_key_i = 1'b0;
    for (int i = 0; i < 100 && !core_init_o; i++) step();
    chk_i("wk_init_seen", int'(core_init_o), 1);
    chk_i("wk_capture_first", int'(result_cnt_o), 2);
    chk_i("wk_issued_kept", int'(issued_cnt_o), 2);
    chk_w("wk_key", core_key_o, Key2);
    for (int i = 0; i < 1000 && !done_o; i++) step();
    chk_i("wk_done", int'(done_o), 1);
    chk_i("wk_issued", int'(issued_cnt_o), 6);
    chk_i("wk_results", int'(result_cnt_o), 6);
    drain("wk");

    // Continuous run with no pops: issue must stall at FIFO depth.
    block_count_i = '0;
    pop_mode = 0;
    n_next = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (200) step();
    chk_i("full_issued", int'(issued_cnt_o), Depth);
    chk_i("full_results", int'(result_cnt_o), Depth);
    chk_i("full_next_pulses", n_next, Depth);
    chk_i("full_busy", int'(busy_o), 1);
    chk_i("full_done", int'(done_o), 0);
    chk_i("full_data_empty", int'(data_empty_o), 0);
    work_i = 1'b0;
    drain("full");
    chk_i("full_busy_after", int'(busy_o), 1);

    // Resume, then reset with a block in flight.
    work_i = 1'b1;
    n_next = 0;
    for (int i = 0; i < 20 && n_next < 1; i++) step();
    chk_i("resume_issue", n_next, 1);
    step();
    rst_n = 1'b0;
    #1;
    chk_i("midrst_busy", int'(busy_o), 1);
    chk_i("midrst_data_empty", int'(data_empty_o), 1);
    chk_i("midrst_result_empty", int'(result_empty_o), 1);
    chk_i("midrst_issued", int'(issued_cnt_o), 0);
    chk_w("midrst_key", core_key_o, KeyRst);
    exp_pt.delete();
    exp_res.delete();
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 60 && busy_o; i++) step();
    chk_i("midrst_back_idle", int'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
